// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan driver.
//   FONT       : 16-entry hex font, active-low {g,f,e,d,c,b,a}
//   SEG_OFF    : all segments (and dp) off
//   AN_OFF     : all anodes off
//   NUM_DIGITS : digits per frame
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam logic [7:0]  SEG_OFF    = 8'hFF;
    localparam logic [7:0]  AN_OFF     = 8'hFF;

    // Packed so FONT[n] selects the glyph for nibble n; entry 15 is listed first.
    localparam logic [15:0][6:0] FONT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic {StBlank, StDrive} scan_state_e;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Load channel into the scan driver.
//   data_i  : 32-bit value, nibble k shown on digit k
//   valid_i : single-cycle load strobe
//   dp_i    : decimal-point enables, bit k for digit k
// master drives the channel, slave (the driver) receives it.
interface seg7_scan_driver_if;

    logic [31:0] data_i;
    logic        valid_i;
    logic [7:0]  dp_i;

    modport master (output data_i, output valid_i, output dp_i);
    modport slave  (input  data_i, input  valid_i, input  dp_i);

endinterface

// File: rtl/seg7_hex_font.sv
// Combinational hex-to-seven-segment decoder.
//   nibble_i : 4-bit value
//   seg_o    : active-low {g,f,e,d,c,b,a}
module seg7_hex_font
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = FONT[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
//   clk, rstn    : clock, asynchronous active-low reset
//   load         : value/dp load channel (slave side)
//   blank_lz_i   : live leading-zero blanking enable
//   disp_an_o    : active-low anode enables, bit k for digit k
//   disp_seg_o   : active-low {dp,g,f,e,d,c,b,a}
//   frame_done_o : one-cycle pulse after each 8-digit frame
// Loads land in a shadow register and are committed only at a frame boundary.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 100000,
    parameter int unsigned BLANK_CYC = 1000
) (
    input  logic                clk,
    input  logic                rstn,
    seg7_scan_driver_if.slave   load,
    input  logic                blank_lz_i,
    output logic [7:0]          disp_an_o,
    output logic [7:0]          disp_seg_o,
    output logic                frame_done_o
);

    localparam int unsigned      CNT_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       digit_q, digit_d;
    scan_state_e      state_q, state_d;
    logic [31:0]      shadow_q, shadow_d, disp_q, disp_d;
    logic [7:0]       shadow_dp_q, shadow_dp_d, disp_dp_q, disp_dp_d;
    logic             pending_q, pending_d;
    logic [7:0]       an_q, an_d, seg_q, seg_d;
    logic             frame_done_q, frame_done_d;

    logic             slot_end, commit;
    logic [3:0]       nibble;
    logic [6:0]       font_seg;
    logic [7:0]       upper_zero;

    assign slot_end = (cnt_q == CNT_LAST);
    assign commit   = slot_end && (digit_q == 3'd7);

    always_comb begin
        cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
        digit_d = slot_end ? digit_q + 3'd1 : digit_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StBlank: if (BLANK_CYC == 0 || cnt_q == BLANK_LAST) state_d = StDrive;
            // With no gap configured the driver never leaves DRIVE.
            StDrive: if (slot_end) state_d = (BLANK_CYC == 0) ? StDrive : StBlank;
            default: state_d = StBlank;
        endcase
    end

    // Commit reads the pre-edge shadow, so a load in the commit cycle waits a frame.
    always_comb begin
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        pending_d   = pending_q;
        disp_d      = disp_q;
        disp_dp_d   = disp_dp_q;
        if (commit) begin
            if (pending_q) begin
                disp_d    = shadow_q;
                disp_dp_d = shadow_dp_q;
            end
            pending_d = 1'b0;
        end
        if (load.valid_i) begin
            shadow_d    = load.data_i;
            shadow_dp_d = load.dp_i;
            pending_d   = 1'b1;
        end
    end

    // upper_zero[k]: nibbles k..7 of the displayed value are all zero.
    always_comb begin
        upper_zero = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            upper_zero[k] = ((disp_q >> (4 * k)) == 32'd0);
        end
    end

    assign nibble = disp_q[{digit_q, 2'b00} +: 4];

    seg7_hex_font u_font (
        .nibble_i (nibble),
        .seg_o    (font_seg)
    );

    always_comb begin
        an_d         = AN_OFF;
        seg_d        = SEG_OFF;
        frame_done_d = commit;
        if (state_q == StDrive) begin
            an_d = ~(8'b1 << digit_q);
            if (!(blank_lz_i && digit_q != 3'd0 && upper_zero[digit_q])) begin
                seg_d = {~disp_dp_q[digit_q], font_seg};
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q        <= '0;
            digit_q      <= '0;
            state_q      <= StBlank;
            shadow_q     <= '0;
            shadow_dp_q  <= '0;
            pending_q    <= 1'b0;
            disp_q       <= '0;
            disp_dp_q    <= '0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            pending_q    <= pending_d;
            disp_q       <= disp_d;
            disp_dp_q    <= disp_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign disp_an_o    = an_q;
    assign disp_seg_o   = seg_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (CLK_DIV=8, BLANK_CYC=2).
module tb_seg7_scan_driver;

    localparam int unsigned CLK_DIV   = 8;
    localparam int unsigned BLANK_CYC = 2;
    localparam int unsigned FRAME     = CLK_DIV * 8;

    localparam logic [6:0] FONT_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic       clk = 1'b0;
    logic       rstn;
    logic       blank_lz;
    logic [7:0] an, seg;
    logic       fd;
    logic       sb_en = 1'b0;

    seg7_scan_driver_if lif ();

    seg7_scan_driver #(
        .CLK_DIV   (CLK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .load         (lif),
        .blank_lz_i   (blank_lz),
        .disp_an_o    (an),
        .disp_seg_o   (seg),
        .frame_done_o (fd)
    );

    always #5 clk = ~clk;

    int n_pass   = 0;
    int n_checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: everything derives from t, cycles elapsed since reset release.
    function automatic logic [7:0] ref_an(input int unsigned t);
        int unsigned pos = t % CLK_DIV;
        int unsigned dig = (t / CLK_DIV) % 8;
        if (pos < BLANK_CYC) return 8'hFF;
        return ~(8'h01 << dig);
    endfunction

    function automatic logic [7:0] ref_seg(input int unsigned t, input logic [31:0] v,
                                           input logic [7:0] dp, input logic lz);
        int unsigned pos = t % CLK_DIV;
        int unsigned dig = (t / CLK_DIV) % 8;
        logic [31:0] upper = v >> (4 * dig);
        if (pos < BLANK_CYC) return 8'hFF;
        if (lz && dig != 0 && upper == 32'd0) return 8'hFF;
        return {~dp[dig], FONT_TAB[upper[3:0]]};
    endfunction

    function automatic bit ref_commit(input int unsigned t);
        return (t % FRAME) == FRAME - 1;
    endfunction

    int unsigned m_t;
    logic [31:0] m_disp, m_sh;
    logic [7:0]  m_dp, m_shdp;
    logic        m_pend;
    logic [7:0]  exp_an, exp_seg;
    logic        exp_fd;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_t <= 0; m_disp <= '0; m_sh <= '0; m_dp <= '0; m_shdp <= '0; m_pend <= 1'b0;
            exp_an <= 8'hFF; exp_seg <= 8'hFF; exp_fd <= 1'b0;
        end else begin
            exp_an  <= ref_an(m_t);
            exp_seg <= ref_seg(m_t, m_disp, m_dp, blank_lz);
            exp_fd  <= ref_commit(m_t);
            if (ref_commit(m_t) && m_pend) begin
                m_disp <= m_sh;
                m_dp   <= m_shdp;
            end
            if (lif.valid_i) begin
                m_sh <= lif.data_i; m_shdp <= lif.dp_i; m_pend <= 1'b1;
            end else if (ref_commit(m_t)) begin
                m_pend <= 1'b0;
            end
            m_t <= m_t + 1;
        end
    end

    always @(negedge clk) begin
        if (sb_en) check("scoreboard {an,seg,fd}", {15'd0, an, seg, fd},
                         {15'd0, exp_an, exp_seg, exp_fd});
    end

    typedef struct {
        logic [31:0] data;
        logic [7:0]  dp;
        logic        lz;
        logic [63:0] exp;  // {d7,...,d0}
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] got [8];
    logic [7:0] seq_a [12];

    task automatic drive_load(input logic [31:0] d, input logic [7:0] p);
        lif.data_i  = d;
        lif.dp_i    = p;
        lif.valid_i = 1'b1;
        @(negedge clk);
        lif.valid_i = 1'b0;
    endtask

    task automatic wait_fd();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fd !== 1'b1 && n < 3 * FRAME);
        check("frame_done_seen", {31'd0, fd}, 32'd1);
    endtask

    // Observe one frame starting after an fd cycle; ends on the next fd cycle.
    task automatic sample_frame();
        int pulses = 0;
        for (int d = 0; d < 8; d++) got[d] = 8'hxx;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (fd === 1'b1) pulses++;
            for (int d = 0; d < 8; d++) begin
                if (an === ~(8'h01 << d)) got[d] = seg;
            end
        end
        check("frame_done_once", pulses, 1);
    endtask

    task automatic compare_frame(input string name, input logic [63:0] exp);
        for (int d = 0; d < 8; d++) begin
            check($sformatf("%s digit%0d seg", name, d), {24'd0, got[d]},
                  {24'd0, exp[8*d +: 8]});
        end
    endtask

    initial begin
        vecs[0] = '{32'h1234ABCD, 8'h00, 1'b0, 64'hF9A4B0998883C6A1};
        vecs[1] = '{32'h00000305, 8'h00, 1'b1, 64'hFFFFFFFFFFB0C092};
        vecs[2] = '{32'h00000000, 8'h00, 1'b1, 64'hFFFFFFFFFFFFFFC0};
        vecs[3] = '{32'h00000005, 8'h01, 1'b0, 64'hC0C0C0C0C0C0C012};
        vecs[4] = '{32'h00000005, 8'h01, 1'b1, 64'hFFFFFFFFFFFFFF12};
        vecs[5] = '{32'h89ABCDEF, 8'hAA, 1'b0, 64'h0090088346A1068E};
        vecs[6] = '{32'h00000010, 8'hFF, 1'b1, 64'hFFFFFFFFFFFF7940};
        vecs[7] = '{32'h00000000, 8'h00, 1'b0, 64'hC0C0C0C0C0C0C0C0};
        seq_a = '{8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE,
                  8'hFF, 8'hFF, 8'hFD};

        rstn = 1'b1; blank_lz = 1'b0;
        lif.valid_i = 1'b0; lif.data_i = '0; lif.dp_i = '0;
        #1 rstn = 1'b0;
        #1;
        check("reset an", {24'd0, an}, 32'hFF);
        check("reset seg", {24'd0, seg}, 32'hFF);
        check("reset fd", {31'd0, fd}, 32'd0);
        sb_en = 1'b1;
        repeat (3) @(negedge clk);

        // Release and follow the first slots.
        rstn = 1'b1;
        check("release an[0]", {24'd0, an}, {24'd0, seq_a[0]});
        for (int i = 1; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("release an[%0d]", i), {24'd0, an}, {24'd0, seq_a[i]});
            if (i >= 3 && i <= 8) check($sformatf("release seg[%0d]", i), {24'd0, seg}, 32'hC0);
        end
        wait_fd();
        sample_frame();
        compare_frame("zero frame", 64'hC0C0C0C0C0C0C0C0);

        // Table: load mid-frame, it shows from the frame after the next commit.
        for (int v = 0; v < 8; v++) begin
            repeat (3) @(negedge clk);
            blank_lz = vecs[v].lz;
            drive_load(vecs[v].data, vecs[v].dp);
            wait_fd();
            sample_frame();
            compare_frame($sformatf("vec%0d", v), vecs[v].exp);
        end

        // Load landing exactly in the commit cycle, with an older load pending.
        blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        drive_load(32'h11111111, 8'h00);
        repeat (59) @(negedge clk);
        lif.data_i = 32'hFFFFFFFF; lif.dp_i = 8'h00; lif.valid_i = 1'b1;
        @(negedge clk);
        lif.valid_i = 1'b0;
        check("collision fd aligned", {31'd0, fd}, 32'd1);
        sample_frame();
        compare_frame("collision first", 64'hF9F9F9F9F9F9F9F9);
        sample_frame();
        compare_frame("collision second", 64'h8E8E8E8E8E8E8E8E);

        // Random loads, data widths and blanking toggles against the model.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            lif.valid_i = ($urandom_range(0, 5) == 0);
            lif.data_i  = $urandom >> (4 * $urandom_range(0, 7));
            lif.dp_i    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
        end
        @(negedge clk);
        lif.valid_i = 1'b0;
        blank_lz = 1'b0;

        // Reset during DRIVE of digit 4 with a load pending.
        drive_load(32'h77777777, 8'hFF);
        begin
            int n = 0;
            while (an !== 8'hEF && n < 2 * FRAME) begin
                @(negedge clk);
                n++;
            end
            check("digit4 reached", {24'd0, an}, 32'hEF);
        end
        #2 rstn = 1'b0;
        #1;
        check("async reset an", {24'd0, an}, 32'hFF);
        check("async reset seg", {24'd0, seg}, 32'hFF);
        check("async reset fd", {31'd0, fd}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        begin
            int n = 0;
            while (an === 8'hFF && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("restart an", {24'd0, an}, 32'hFE);
            check("restart seg", {24'd0, seg}, 32'hC0);
        end
        wait_fd();
        sample_frame();
        compare_frame("after reset", 64'hC0C0C0C0C0C0C0C0);

        sb_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
